// File: rtl/qsys_tg_pkg.sv
// Shared constants and types for the Avalon-MM traffic generator.
// Id fields are ID_W bits wide and are located by their offset below the data MSB.
package qsys_tg_pkg;

  localparam int MODE_READ  = 0;
  localparam int MODE_WRITE = 1;
  localparam int MODE_ALT   = 2;

  localparam int ID_W        = 8;
  localparam int SRC_MSB_OFS = 0;
  localparam int DST_MSB_OFS = ID_W;
  localparam int SEQ_MSB_OFS = 2 * ID_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } tg_state_t;

endpackage

// File: rtl/qsys_tg_fifo.sv
// Single-clock in-order FIFO with look-ahead output (head entry always visible on dout).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module qsys_tg_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/qsys_traffic_master.sv
// Avalon-MM traffic generator: round-robin bursts over NUM_SLAVES, in-order read checking.
// Define QSYS_TRAFFIC_MASTER_LATENCY_EN to add read-latency statistics (lat_min/lat_max/lat_sum).
module qsys_traffic_master
  import qsys_tg_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int ADDR_WIDTH       = 40,
  parameter int SRC_ID           = 2,
  parameter int NUM_SLAVES       = 2,
  parameter int BURST_SIZE       = 1,
  parameter int MODE             = 0,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int NUM_TRANSACTIONS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic [WIDTH-1:0]      writedata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic                  read,
  input  logic [WIDTH-1:0]      readdata,
  input  logic                  readdatavalid,
  input  logic                  waitrequest,
  output logic [31:0]           tx_count,
  output logic [31:0]           rsp_count,
  output logic [15:0]           err_count,
  output logic [6:0]            outstanding,
  output logic [31:0]           lat_min,
  output logic [31:0]           lat_max,
  output logic [31:0]           lat_sum
);
  localparam int SEQ_W = WIDTH - SEQ_MSB_OFS;
  localparam int SEL_W = ADDR_WIDTH - 32;
`ifdef QSYS_TRAFFIC_MASTER_LATENCY_EN
  localparam int ENT_W = ID_W + 32;
`else
  localparam int ENT_W = ID_W;
`endif

  tg_state_t             state_reg;
  logic [ID_W-1:0]       slave_reg, slave_next;
  logic [31:0]           burst_reg, burst_next, tx_next;
  logic [SEQ_W-1:0]      seq_reg, seq_next;
  logic                  dir_wr_reg, dir_wr_next;
  logic                  accept, rd_accept, rsp_pop, hold, want_wr, issue_ok;
  logic [6:0]            out_next;
  logic [WIDTH-1:0]      wdata_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  fifo_push, fifo_full, fifo_empty, id_mismatch;
  logic [ENT_W-1:0]      fifo_din, fifo_dout;
  logic                  unused_rdata;

  assign unused_rdata = ^readdata[WIDTH-ID_W-1:0];
  assign done         = (state_reg == DONE);

  always_comb begin
    accept      = (read || write) && !waitrequest;
    rd_accept   = accept && read;
    hold        = (read || write) && waitrequest;
    rsp_pop     = readdatavalid && !fifo_empty;
    out_next    = outstanding + 7'(rd_accept) - 7'(rsp_pop);
    tx_next     = tx_count + 32'(accept);
    seq_next    = seq_reg + SEQ_W'(accept);
    slave_next  = slave_reg;
    burst_next  = burst_reg;
    dir_wr_next = dir_wr_reg;
    if (accept) begin
      if (burst_reg == 32'd1) begin
        burst_next = 32'(BURST_SIZE);
        slave_next = (slave_reg == ID_W'(NUM_SLAVES - 1)) ? '0 : slave_reg + 1'b1;
        if (MODE == MODE_ALT) dir_wr_next = !dir_wr_reg;
      end else begin
        burst_next = burst_reg - 32'd1;
      end
    end
    want_wr  = (MODE == MODE_WRITE) || ((MODE == MODE_ALT) && dir_wr_next);
    // A read needs a free response credit; writes never wait for one.
    issue_ok = (tx_next < 32'(NUM_TRANSACTIONS)) &&
               (want_wr || (out_next < 7'(MAX_OUTSTANDING)));
    wdata_next = '0;
    wdata_next[WIDTH-1-SRC_MSB_OFS -: ID_W]  = ID_W'(SRC_ID);
    wdata_next[WIDTH-1-DST_MSB_OFS -: ID_W]  = slave_next;
    wdata_next[WIDTH-1-SEQ_MSB_OFS -: SEQ_W] = seq_next;
    addr_next = {SEL_W'(slave_next), 32'h0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      slave_reg  <= '0;
      burst_reg  <= 32'(BURST_SIZE);
      seq_reg    <= '0;
      dir_wr_reg <= 1'b0;
      tx_count   <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
    end else begin
      slave_reg  <= slave_next;
      burst_reg  <= burst_next;
      seq_reg    <= seq_next;
      dir_wr_reg <= dir_wr_next;
      tx_count   <= tx_next;
      case (state_reg)
        IDLE: if (start) begin
          state_reg <= RUN;
          read      <= issue_ok && !want_wr;
          write     <= issue_ok && want_wr;
          address   <= addr_next;
          writedata <= wdata_next;
        end
        RUN: begin
          if (!hold) begin
            read      <= issue_ok && !want_wr;
            write     <= issue_ok && want_wr;
            address   <= addr_next;
            writedata <= wdata_next;
          end
          if (accept && (tx_next == 32'(NUM_TRANSACTIONS)))
            state_reg <= (out_next == '0) ? DONE : DRAIN;
        end
        DRAIN: if (out_next == '0) state_reg <= DONE;
        default: ;
      endcase
    end
  end

  assign fifo_push   = rd_accept && (!fifo_full || rsp_pop);
  assign id_mismatch = fifo_dout[ENT_W-1 -: ID_W] != readdata[WIDTH-1-SRC_MSB_OFS -: ID_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      rsp_count   <= '0;
      err_count   <= '0;
    end else begin
      outstanding <= out_next;
      if (rsp_pop) rsp_count <= rsp_count + 32'd1;
      // Unexpected responses and wrong responders both count; the counter saturates.
      if (readdatavalid && (!rsp_pop || id_mismatch) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

`ifdef QSYS_TRAFFIC_MASTER_LATENCY_EN
  logic [31:0] cyc_reg, lat;
  logic [32:0] sum_ext;

  assign fifo_din = {slave_reg, cyc_reg};
  assign lat      = cyc_reg - fifo_dout[31:0];
  assign sum_ext  = {1'b0, lat_sum} + {1'b0, lat};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_reg <= '0;
      lat_min <= 32'hFFFF_FFFF;
      lat_max <= '0;
      lat_sum <= '0;
    end else begin
      cyc_reg <= cyc_reg + 32'd1;
      if (rsp_pop) begin
        if (lat < lat_min) lat_min <= lat;
        if (lat > lat_max) lat_max <= lat;
        lat_sum <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
      end
    end
  end
`else
  assign fifo_din = slave_reg;
  assign lat_min  = '0;
  assign lat_max  = '0;
  assign lat_sum  = '0;
`endif

  qsys_tg_fifo #(
    .DW    (ENT_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (rsp_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/qsys_traffic_master.md
Name: qsys_traffic_master

Overview:
- Parametrised Avalon-MM traffic-generator master for NoC/Qsys performance evaluation.
- Issues read and/or write transactions round-robin across NUM_SLAVES slaves, in bursts of BURST_SIZE per slave.
- Enforces an outstanding-read limit and checks that read responses return in order from the expected slave.
- Reports transaction, response and error counts, and asserts done once NUM_TRANSACTIONS have been issued and fully drained.

Parameters:
- WIDTH, 32: data width; must be >= 24.
- ADDR_WIDTH, 40: address width; must be > 32. Upper ADDR_WIDTH-32 bits select the slave.
- SRC_ID, 2: 8-bit id of this master, placed in writedata[WIDTH-1 -: 8].
- NUM_SLAVES, 2: slaves targeted; must be >= 1.
- BURST_SIZE, 1: consecutive transactions per slave before advancing; must be >= 1.
- MODE, 0: 0 = read only, 1 = write only, 2 = alternate read/write at each burst boundary, starting with read.
- MAX_OUTSTANDING, 4: read-response credit limit; power of 2, 1..64.
- NUM_TRANSACTIONS, 1000: total commands to issue.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that leaves IDLE.
- done, out, 1: high in DONE.
- writedata, out, WIDTH: {SRC_ID, dst_id, seq}. dst_id = current slave index (8 b); seq = issue counter, WIDTH-16 b.
- address, out, ADDR_WIDTH: {slave index zero-extended, 32'h0}.
- write, out, 1: Avalon write request.
- read, out, 1: Avalon read request.
- readdata, in, WIDTH: response; [WIDTH-1 -: 8] = responder id.
- readdatavalid, in, 1: response valid.
- waitrequest, in, 1: slave stall.
- tx_count, out, 32: accepted commands.
- rsp_count, out, 32: read responses received.
- err_count, out, 16: saturating error count.
- outstanding, out, 7: reads in flight.
- lat_min, out, 32: latency statistic (optional feature).
- lat_max, out, 32: latency statistic (optional feature).
- lat_sum, out, 32: latency statistic (optional feature).

Behaviour:
- Reset values:
  - All outputs 0, except lat_min = 32'hFFFF_FFFF when the feature is enabled.
  - State IDLE; slave index 0; burst counter BURST_SIZE; seq 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN in the cycle the NUM_TRANSACTIONS-th command is accepted.
  - DRAIN -> DONE when outstanding == 0, and that check is also made in the same cycle RUN is left.
  - DONE is sticky until reset; start is ignored outside IDLE.
- Issue (RUN):
  - The command is registered. read/write/address/writedata are held stable while waitrequest = 1.
  - Acceptance = (read|write) && !waitrequest. Back-to-back issue is allowed; the next command is presented the cycle after acceptance.
  - A read is not presented when outstanding == MAX_OUTSTANDING. In that cycle read and write are both 0; no bubble is added otherwise.
  - Never assert read and write together.
- Per acceptance:
  - seq and tx_count increment; burst counter decrements.
  - At burst counter 0: reload BURST_SIZE; slave index = (index+1) mod NUM_SLAVES (wraps from NUM_SLAVES-1 to 0); in MODE 2, toggle direction.
- Read tracking:
  - Each accepted read pushes dst_id into an in-order FIFO of depth MAX_OUTSTANDING.
  - Each readdatavalid pops the FIFO; rsp_count increments.
  - Responder id != popped dst_id -> err_count += 1.
- Outstanding counter:
  - Read accept and response in the same cycle -> net 0.
  - readdatavalid with outstanding == 0 -> err_count += 1; no pop, no underflow.
  - readdatavalid is processed in every state, including IDLE and DONE.
- err_count saturates at 16'hFFFF. seq wraps modulo 2^(WIDTH-16).
- Reset asserted mid-transaction: all state is cleared immediately; in-flight responses arriving later count as unexpected errors.

Optional Feature:
- Macro QSYS_TRAFFIC_MASTER_LATENCY_EN.
- Defined:
  - A free-running 32-bit cycle counter starts at 0 on reset; each FIFO entry also stores the issue timestamp.
  - On each valid pop: latency = now - stamp, modulo 2^32.
  - lat_min/lat_max update with compare.
  - lat_sum accumulates and saturates at 32'hFFFF_FFFF.
- Undefined:
  - No timestamp storage or counter; lat_min, lat_max and lat_sum are tied to 0.

Decomposition:
- Package qsys_tg_pkg holds:
  - MODE_READ/MODE_WRITE/MODE_ALT constants.
  - State enum tg_state_t (IDLE, RUN, DRAIN, DONE).
  - Field position constants for the ID_W = 8 id fields.
- Sub-module qsys_tg_fifo: synchronous single-clock FIFO, parameterised width/depth, with push/pop/full/empty, same async active-low reset. It is used for the outstanding-read queue.

Test Plan:
- MODE 0, NUM_SLAVES 2, BURST_SIZE 2, NUM_TRANSACTIONS 8, slave model with 3-cycle read latency and no waitrequest -> address slave field sequence 0,0,1,1,0,0,1,1; done after the 8th response; tx_count = rsp_count = 8; err_count = 0.
- waitrequest held high 5 cycles mid-run -> read, address and writedata stable for all 5 cycles; exactly one acceptance afterwards.
- MAX_OUTSTANDING 4, slave delays responses 20 cycles -> outstanding peaks at 4; read deasserted while full; resumes the cycle after the first response.
- MODE 2, BURST_SIZE 3, NUM_TRANSACTIONS 12 -> pattern R,R,R,W,W,W repeated; rsp_count = 6.
- Wrong responder id on response 2, plus one spurious readdatavalid after DONE -> err_count = 2; done stays 1.
- With the latency macro, fixed 3-cycle latency over 8 reads -> lat_min = lat_max = 3 (measured acceptance to readdatavalid); lat_sum = 24. Then assert rst low mid-run -> all counters 0 and lat_min = FFFF_FFFF on the same edge.
